// File: rtl/quad_decoder_modn.sv
// Quadrature A/B decoder: synchronize, glitch-filter, Gray-decode, mod-N position.
module quad_decoder_modn #(
  parameter int unsigned N    = 10,
  parameter int unsigned W    = 4,
  parameter int unsigned FILT = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         a_in,
  input  logic         b_in,
  input  logic         clear,
  input  logic         err_clr,
  output logic [W-1:0] count,
  output logic         dir,
  output logic         step,
  output logic         err
);

  // Two-flop synchronizers for both phases, kept as {a,b} pairs
  logic [1:0] sync1_q, sync2_q;

  // Filter history, newest entry at index 0
  logic [FILT-1:0][1:0] sh_q, sh_d;

  // Accepted phase, the phase it replaced, and a one-cycle "changed" marker
  logic [1:0] filt_ab_q, filt_ab_d;
  logic [1:0] prev_ab_q, prev_ab_d;
  logic       chg_q, chg_d;
  logic       init_done_q, init_done_d;

  // Outputs
  logic [W-1:0] count_q, count_d;
  logic         dir_q, dir_d;
  logic         step_q, step_d;
  logic         err_q, err_d;

  logic       stable_c;
  logic       accept_c;
  logic [1:0] delta_c;

  // Position of a phase value in the Gray cycle 00->01->11->10
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    logic [1:0] idx;
    case (ab)
      2'b00:   idx = 2'd0;
      2'b01:   idx = 2'd1;
      2'b11:   idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Filter: shift in synchronized phase, accept once history is unanimous
  always_comb begin
    sh_d        = sh_q;
    sh_d[0]     = sync2_q;
    for (int unsigned i = 1; i < FILT; i++) begin
      sh_d[i] = sh_q[i-1];
    end
    stable_c = 1'b1;
    for (int unsigned i = 1; i < FILT; i++) begin
      if (sh_q[i] != sh_q[0]) stable_c = 1'b0;
    end
    accept_c    = stable_c && (sh_q[0] != filt_ab_q);
    filt_ab_d   = accept_c ? sh_q[0] : filt_ab_q;
    prev_ab_d   = accept_c ? filt_ab_q : prev_ab_q;
    // The first settled value after reset only establishes the reference phase
    chg_d       = accept_c && init_done_q;
    init_done_d = init_done_q | stable_c;
  end

  // Decode one Gray transition per change and update the mod-N position
  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    err_d   = err_q;
    delta_c = gray_idx(filt_ab_q) - gray_idx(prev_ab_q);
    if (err_clr) err_d = 1'b0;
    if (chg_q) begin
      case (delta_c)
        2'd1: begin
          step_d  = 1'b1;
          dir_d   = 1'b1;
          count_d = (count_q == W'(N - 1)) ? '0 : count_q + W'(1);
        end
        2'd3: begin
          step_d  = 1'b1;
          dir_d   = 1'b0;
          count_d = (count_q == '0) ? W'(N - 1) : count_q - W'(1);
        end
        2'd2:    err_d = 1'b1;
        default: ;
      endcase
    end
    // Clear overrides the position but the step/dir report is kept
    if (clear) count_d = '0;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sh_q        <= '0;
      filt_ab_q   <= '0;
      prev_ab_q   <= '0;
      chg_q       <= 1'b0;
      init_done_q <= 1'b0;
      count_q     <= '0;
      dir_q       <= 1'b0;
      step_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sync1_q     <= {a_in, b_in};
      sync2_q     <= sync1_q;
      sh_q        <= sh_d;
      filt_ab_q   <= filt_ab_d;
      prev_ab_q   <= prev_ab_d;
      chg_q       <= chg_d;
      init_done_q <= init_done_d;
      count_q     <= count_d;
      dir_q       <= dir_d;
      step_q      <= step_d;
      err_q       <= err_d;
    end
  end

  assign count = count_q;
  assign dir   = dir_q;
  assign step  = step_q;
  assign err   = err_q;

endmodule

// File: tb/tb_quad_decoder_modn.sv
// Scoreboard bench for quad_decoder_modn: encoder moves push expected events,
// a negedge monitor pops and compares whenever step pulses or err rises.
module tb_quad_decoder_modn;

  localparam int N    = 10;
  localparam int W    = 4;
  localparam int FILT = 2;
  localparam int LAT  = FILT + 4;  // drive after edge c -> visible after edge c+LAT

  logic         clk = 1'b0;
  logic         reset;
  logic         a_in, b_in, clear, err_clr;
  logic [W-1:0] count;
  logic         dir, step, err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int cyc;
    bit is_err;
    int cnt;
    bit dir;
  } exp_t;
  exp_t q[$];

  // Reference model: Gray phase index, position, last direction
  logic [1:0] gray_v [4];
  int ph   = 0;
  int pos  = 0;
  bit mdir = 0;

  quad_decoder_modn #(.N(N), .W(W), .FILT(FILT)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in),
    .clear(clear), .err_clr(err_clr),
    .count(count), .dir(dir), .step(step), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expectation per step pulse or err rising edge
  bit step_prev = 0, err_prev = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      step_prev = 0;
      err_prev  = 0;
    end else begin
      checks++;
      if (int'(count) >= N) begin
        errors++;
        $display("FAIL count_range: got %0d expected < %0d", count, N);
      end
      if (step && step_prev) begin
        checks++; errors++;
        $display("FAIL step_width: got 2-cycle pulse expected 1 at cycle %0d", cyc);
      end
      if (step || (err && !err_prev)) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got step=%0d err=%0d count=%0d expected none at cycle %0d",
                   step, err, count, cyc);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || int'(count) != e.cnt || dir != e.dir ||
              step != !e.is_err || (e.is_err && !err)) begin
            errors++;
            $display("FAIL event: got cyc=%0d step=%0d err=%0d count=%0d dir=%0d expected cyc=%0d err_evt=%0d count=%0d dir=%0d",
                     cyc, step, err, count, dir, e.cyc, e.is_err, e.cnt, e.dir);
          end
        end
      end
      step_prev = step;
      err_prev  = err;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind 0 = forward, 1 = reverse, 2 = illegal (both phases flip)
  task automatic move(input int kind, input int hold);
    int np;
    logic [1:0] ab;
    exp_t e;
    np = (kind == 0) ? (ph + 1) % 4 : (kind == 1) ? (ph + 3) % 4 : (ph + 2) % 4;
    ab = gray_v[np];
    a_in = ab[1];
    b_in = ab[0];
    ph = np;
    if (kind == 0) begin pos = (pos + 1) % N;     mdir = 1; end
    if (kind == 1) begin pos = (pos + N - 1) % N; mdir = 0; end
    e.cyc = cyc + LAT; e.is_err = (kind == 2); e.cnt = pos; e.dir = mdir;
    q.push_back(e);
    tick(hold);
  endtask

  task automatic illegal_and_clear();
    move(2, FILT + 6);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("err_after_clr", err, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      tick(1);
      n++;
    end
    check("drain_pending", q.size(), 0);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1; a_in = 1'b0; b_in = 1'b0;
    ph = 0; pos = 0; mdir = 0;
    tick(n);
    reset = 1'b0;
  endtask

  initial begin
    exp_t e;
    gray_v[0] = 2'b00; gray_v[1] = 2'b01; gray_v[2] = 2'b11; gray_v[3] = 2'b10;
    clear = 1'b0; err_clr = 1'b0;
    do_reset(3);

    // Idle 00 after reset: no steps, everything zero
    tick(20);
    check("idle_count", count, 0);
    check("idle_dir", dir, 0);
    check("idle_step", step, 0);
    check("idle_err", err, 0);

    // Four forward steps
    for (int i = 0; i < 4; i++) move(0, 8);
    drain();
    check("fwd4_count", count, 4);
    check("fwd4_dir", dir, 1);

    // Wrap 9->0, then one reverse step 0->9
    for (int i = 0; i < 6; i++) move(0, 8);
    drain();
    check("wrap_count", count, 0);
    move(1, 8);
    drain();
    check("rev_count", count, 9);
    check("rev_dir", dir, 0);

    // One-cycle glitch on a_in is filtered out
    a_in = ~a_in;
    tick(1);
    a_in = ~a_in;
    tick(20);
    check("glitch_count", count, pos);

    // Illegal jump sets err; err_clr clears it; stepping resumes
    illegal_and_clear();
    check("illegal_count", count, 9);
    move(0, 8);
    move(0, 8);
    drain();
    check("resume_count", count, 1);

    // Reach 5, then a forward step coincident with clear
    while (pos != 5) move(0, 6);
    drain();
    check("pre_clear_count", count, 5);
    begin
      int np;
      logic [1:0] ab;
      np = (ph + 1) % 4;
      ab = gray_v[np];
      a_in = ab[1]; b_in = ab[0]; ph = np;
      pos = 0; mdir = 1;
      e.cyc = cyc + LAT; e.is_err = 0; e.cnt = 0; e.dir = 1;
      q.push_back(e);
      tick(LAT - 1);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      check("clear_step_count", count, 0);
      check("clear_step_dir", dir, 1);
      tick(6);
    end

    // Standalone clear
    move(0, 8); move(0, 8);
    drain();
    clear = 1'b1; tick(1); clear = 1'b0;
    pos = 0;
    check("clear_only_count", count, 0);

    // Randomized moves
    for (int i = 0; i < 150; i++) begin
      int r = $urandom_range(0, 99);
      if (r < 5) illegal_and_clear();
      else move((r < 55) ? 0 : 1, $urandom_range(FILT + 1, 10));
    end
    drain();
    check("random_final_count", count, pos);

    // Reset mid-operation after a forward step
    move(0, 8);
    drain();
    reset = 1'b1;
    tick(1);
    check("midrst_count", count, 0);
    check("midrst_dir", dir, 0);
    check("midrst_step", step, 0);
    check("midrst_err", err, 0);
    do_reset(3);
    tick(10);
    for (int i = 0; i < 3; i++) move(0, 7);
    drain();
    check("post_rst_count", count, 3);
    check("post_rst_dir", dir, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
